// File: rtl/priority_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Package  : priority_encoder_pkg
// Brief    : Shared state encoding and bit-mask helpers for the streaming
//            priority encoder. Helpers work on a PE_MAX_W-bit container.
//            Callers zero-extend their mask into it and cast the result back
//            down, so WIDTH must not exceed PE_MAX_W.
// Revision : 1.0 - initial release
// ============================================================================
package priority_encoder_pkg;

  localparam int PE_MAX_W = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } pe_state_e;

  // Lowest set bit as a one-hot value (two's-complement trick).
  function automatic logic [PE_MAX_W-1:0] isolate_lsb(input logic [PE_MAX_W-1:0] m);
    return m & (~m + PE_MAX_W'(1));
  endfunction

  // Highest set bit as a one-hot value; the last set bit seen wins.
  function automatic logic [PE_MAX_W-1:0] isolate_msb(input logic [PE_MAX_W-1:0] m);
    logic [PE_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < PE_MAX_W; i++) begin
      if (m[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Index of a one-hot value; zero input yields index 0.
  function automatic int unsigned onehot_to_idx(input logic [PE_MAX_W-1:0] oh);
    int unsigned r;
    r = 0;
    for (int i = 0; i < PE_MAX_W; i++) begin
      if (oh[i]) r = r | unsigned'(i);
    end
    return r;
  endfunction

  // Number of set bits.
  function automatic int unsigned popcount(input logic [PE_MAX_W-1:0] m);
    int unsigned r;
    r = 0;
    for (int i = 0; i < PE_MAX_W; i++) begin
      r = r + {31'b0, m[i]};
    end
    return r;
  endfunction

endpackage : priority_encoder_pkg
`default_nettype wire

// File: rtl/pe_bit_isolate.sv
`default_nettype none
// ============================================================================
// Module   : pe_bit_isolate
// Brief    : Combinational isolation of the lowest/highest set bit of a mask,
//            the index of the bit selected by MSB_FIRST, and a flag that the
//            mask holds exactly one set bit.
// Revision : 1.0 - initial release
// ============================================================================
module pe_bit_isolate
  import priority_encoder_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  parameter int IDX_W     = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mask_i,
  output logic [WIDTH-1:0] lsb_oh_o,
  output logic [WIDTH-1:0] msb_oh_o,
  output logic [WIDTH-1:0] sel_oh_o,
  output logic [IDX_W-1:0] sel_idx_o,
  output logic             single_o
);

  assign lsb_oh_o = WIDTH'(isolate_lsb(PE_MAX_W'(mask_i)));
  assign msb_oh_o = WIDTH'(isolate_msb(PE_MAX_W'(mask_i)));

  // Scan order is a build-time choice, so pick the isolated bit statically.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign sel_oh_o = msb_oh_o;
    end else begin : g_lsb_first
      assign sel_oh_o = lsb_oh_o;
    end
  endgenerate

  assign sel_idx_o = IDX_W'(onehot_to_idx(PE_MAX_W'(sel_oh_o)));

  // Clearing the lowest set bit leaves nothing exactly when one bit was set.
  assign single_o = (mask_i != '0) && ((mask_i & (mask_i - WIDTH'(1))) == '0);

endmodule : pe_bit_isolate
`default_nettype wire

// File: rtl/priority_encoder_stream.sv
`default_nettype none
// ============================================================================
// Module   : priority_encoder_stream
// Brief    : Accepts a WIDTH-bit word over valid/ready, registers its leftmost
//            and rightmost set bits one-hot, then streams every set bit as an
//            index/one-hot beat with a last flag (LSB-first or MSB-first).
//            An all-zero word produces a single beat flagged bit_zero_o.
// Macro    : PRIORITY_ENCODER_STREAM_COUNT_EN adds bit_cnt_o (popcount of the
//            captured word) and bit_num_o (ordinal of the current beat).
// Revision : 1.0 - initial release
// ============================================================================
module priority_encoder_stream
  import priority_encoder_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  parameter int IDX_W     = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  output logic             data_rdy_o,
  output logic [WIDTH-1:0] data_left_o,
  output logic [WIDTH-1:0] data_right_o,
  output logic [IDX_W-1:0] bit_idx_o,
  output logic [WIDTH-1:0] bit_oh_o,
  output logic             bit_val_o,
  output logic             bit_last_o,
  output logic             bit_zero_o,
  input  logic             bit_rdy_i
`ifdef PRIORITY_ENCODER_STREAM_COUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt_o,
  output logic [IDX_W-1:0]           bit_num_o
`endif
);

  pe_state_e        state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] left_q, left_d;
  logic [WIDTH-1:0] right_q, right_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] w_cap_lsb, w_cap_msb, w_cap_sel;
  logic [IDX_W-1:0] w_cap_idx;
  logic             w_cap_single;
  logic [WIDTH-1:0] w_scan_lsb, w_scan_msb, w_scan_oh;
  logic [IDX_W-1:0] w_scan_idx;
  logic             w_scan_single;
  logic             w_beat_done;
  logic             w_accept;

  // Left/right one-hots of the incoming word, registered on accept.
  pe_bit_isolate #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST), .IDX_W(IDX_W)) u_cap_iso (
    .mask_i   (data_i),
    .lsb_oh_o (w_cap_lsb),
    .msb_oh_o (w_cap_msb),
    .sel_oh_o (w_cap_sel),
    .sel_idx_o(w_cap_idx),
    .single_o (w_cap_single)
  );

  // Current beat, taken from what is left of the captured word.
  pe_bit_isolate #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST), .IDX_W(IDX_W)) u_scan_iso (
    .mask_i   (mask_q),
    .lsb_oh_o (w_scan_lsb),
    .msb_oh_o (w_scan_msb),
    .sel_oh_o (w_scan_oh),
    .sel_idx_o(w_scan_idx),
    .single_o (w_scan_single)
  );

  logic unused_iso;
  assign unused_iso = ^{w_cap_sel, w_cap_idx, w_cap_single, w_scan_lsb, w_scan_msb};

  // Beat outputs derive from registered state; the mask is empty outside
  // SCAN, so one-hot and index read as zero when no beat is offered.
  assign bit_val_o    = (state_q == SCAN);
  assign bit_oh_o     = w_scan_oh;
  assign bit_idx_o    = w_scan_idx;
  assign bit_last_o   = bit_val_o && (w_scan_single || zero_q);
  assign bit_zero_o   = bit_val_o && zero_q;
  assign data_left_o  = left_q;
  assign data_right_o = right_q;

  // Ready also on the last-beat handshake so consecutive words need no gap.
  assign w_beat_done = bit_val_o && bit_rdy_i;
  assign data_rdy_o  = (state_q == IDLE) || (w_beat_done && bit_last_o);
  assign w_accept    = data_val_i && data_rdy_o;

  // Next-state: retire the current beat, then let a new word override.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    left_d  = left_q;
    right_d = right_q;
    zero_d  = zero_q;
    if (w_beat_done) begin
      mask_d = mask_q & ~w_scan_oh;
      if (bit_last_o) begin
        state_d = IDLE;
        zero_d  = 1'b0;
      end
    end
    if (w_accept) begin
      mask_d  = data_i;
      left_d  = w_cap_msb;
      right_d = w_cap_lsb;
      zero_d  = (data_i == '0);
      state_d = SCAN;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      left_q  <= left_d;
      right_q <= right_d;
      zero_q  <= zero_d;
    end
  end

`ifdef PRIORITY_ENCODER_STREAM_COUNT_EN
  localparam int CNT_W = $clog2(WIDTH+1);

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0] bit_num_q, bit_num_d;

  // Popcount latched per word; ordinal advances on every non-final beat.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    bit_num_d = bit_num_q;
    if (w_beat_done && !bit_last_o) begin
      bit_num_d = bit_num_q + IDX_W'(1);
    end
    if (w_accept) begin
      bit_cnt_d = CNT_W'(popcount(PE_MAX_W'(data_i)));
      bit_num_d = '0;
    end
  end

  // Count registers.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      bit_cnt_q <= '0;
      bit_num_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      bit_num_q <= bit_num_d;
    end
  end

  assign bit_cnt_o = bit_cnt_q;
  assign bit_num_o = bit_num_q;
`endif

endmodule : priority_encoder_stream
`default_nettype wire

// File: tb/tb_priority_encoder_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_priority_encoder_stream
// Brief    : Self-checking bench. An LSB-first and an MSB-first instance share
//            every input; a scoreboard queue per instance holds the expected
//            beats of each accepted word and is popped on each handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_priority_encoder_stream;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] oh;
    logic       last;
    logic       zero;
    logic [3:0] cnt;
    logic [2:0] num;
  } beat_t;

  logic       clk = 1'b0;
  logic       srst_i;
  logic [7:0] data_i;
  logic       data_val_i;
  logic       bit_rdy_i;

  logic       rdy_a, rdy_b, val_a, val_b, last_a, last_b, zero_a, zero_b;
  logic [7:0] left_a, left_b, right_a, right_b, oh_a, oh_b;
  logic [2:0] idx_a, idx_b;
`ifdef PRIORITY_ENCODER_STREAM_COUNT_EN
  logic [3:0] cnt_a, cnt_b;
  logic [2:0] num_a, num_b;
`endif

  beat_t      q_a[$];
  beat_t      q_b[$];
  logic [7:0] exp_left, exp_right;
  int         n_cmp  = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  priority_encoder_stream #(.WIDTH(8), .MSB_FIRST(0)) u_dut_lsb (
    .clk_i(clk), .srst_i(srst_i), .data_i(data_i), .data_val_i(data_val_i),
    .data_rdy_o(rdy_a), .data_left_o(left_a), .data_right_o(right_a),
    .bit_idx_o(idx_a), .bit_oh_o(oh_a), .bit_val_o(val_a),
    .bit_last_o(last_a), .bit_zero_o(zero_a), .bit_rdy_i(bit_rdy_i)
`ifdef PRIORITY_ENCODER_STREAM_COUNT_EN
    , .bit_cnt_o(cnt_a), .bit_num_o(num_a)
`endif
  );

  priority_encoder_stream #(.WIDTH(8), .MSB_FIRST(1)) u_dut_msb (
    .clk_i(clk), .srst_i(srst_i), .data_i(data_i), .data_val_i(data_val_i),
    .data_rdy_o(rdy_b), .data_left_o(left_b), .data_right_o(right_b),
    .bit_idx_o(idx_b), .bit_oh_o(oh_b), .bit_val_o(val_b),
    .bit_last_o(last_b), .bit_zero_o(zero_b), .bit_rdy_i(bit_rdy_i)
`ifdef PRIORITY_ENCODER_STREAM_COUNT_EN
    , .bit_cnt_o(cnt_b), .bit_num_o(num_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beats and left/right one-hots of an accepted word.
  task automatic push_word(input logic [7:0] w);
    beat_t e;
    int    pc;
    int    n;
    pc = 0;
    for (int i = 0; i < 8; i++) pc += int'(w[i]);
    exp_left  = 8'h00;
    exp_right = 8'h00;
    for (int i = 0; i < 8; i++)  if (w[i]) exp_left  = 8'b1 << i;
    for (int i = 7; i >= 0; i--) if (w[i]) exp_right = 8'b1 << i;
    if (w == 8'h00) begin
      e = '{idx: 3'd0, oh: 8'h00, last: 1'b1, zero: 1'b1, cnt: 4'd0, num: 3'd0};
      q_a.push_back(e);
      q_b.push_back(e);
    end else begin
      n = 0;
      for (int i = 0; i < 8; i++) begin
        if (w[i]) begin
          e = '{idx: 3'(i), oh: 8'b1 << i, last: (n == pc - 1), zero: 1'b0,
                cnt: 4'(pc), num: 3'(n)};
          q_a.push_back(e);
          n++;
        end
      end
      n = 0;
      for (int i = 7; i >= 0; i--) begin
        if (w[i]) begin
          e = '{idx: 3'(i), oh: 8'b1 << i, last: (n == pc - 1), zero: 1'b0,
                cnt: 4'(pc), num: 3'(n)};
          q_b.push_back(e);
          n++;
        end
      end
    end
  endtask

  // One clock: drive inputs after the falling edge, check, then step.
  task automatic cyc(input logic [7:0] d, input logic v, input logic r);
    logic ev, er;
    data_i     = d;
    data_val_i = v;
    bit_rdy_i  = r;
    #1;
    ev = (q_a.size() != 0);
    er = !ev || (r && q_a[0].last);
    chk("val_a", {31'b0, val_a}, {31'b0, ev});
    chk("val_b", {31'b0, val_b}, {31'b0, ev});
    chk("rdy_a", {31'b0, rdy_a}, {31'b0, er});
    chk("rdy_b", {31'b0, rdy_b}, {31'b0, er});
    chk("left_a", {24'b0, left_a}, {24'b0, exp_left});
    chk("right_a", {24'b0, right_a}, {24'b0, exp_right});
    chk("left_b", {24'b0, left_b}, {24'b0, exp_left});
    chk("right_b", {24'b0, right_b}, {24'b0, exp_right});
    if (ev) begin
      chk("idx_a", {29'b0, idx_a}, {29'b0, q_a[0].idx});
      chk("oh_a", {24'b0, oh_a}, {24'b0, q_a[0].oh});
      chk("last_a", {31'b0, last_a}, {31'b0, q_a[0].last});
      chk("zero_a", {31'b0, zero_a}, {31'b0, q_a[0].zero});
      chk("idx_b", {29'b0, idx_b}, {29'b0, q_b[0].idx});
      chk("oh_b", {24'b0, oh_b}, {24'b0, q_b[0].oh});
      chk("last_b", {31'b0, last_b}, {31'b0, q_b[0].last});
      chk("zero_b", {31'b0, zero_b}, {31'b0, q_b[0].zero});
`ifdef PRIORITY_ENCODER_STREAM_COUNT_EN
      chk("cnt_a", {28'b0, cnt_a}, {28'b0, q_a[0].cnt});
      chk("num_a", {29'b0, num_a}, {29'b0, q_a[0].num});
      chk("cnt_b", {28'b0, cnt_b}, {28'b0, q_b[0].cnt});
      chk("num_b", {29'b0, num_b}, {29'b0, q_b[0].num});
`endif
      if (r) begin
        void'(q_a.pop_front());
        void'(q_b.pop_front());
      end
    end
    if (er && v) push_word(d);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Consume outstanding beats; mode 0 always ready, 1 ready pattern 1,0,0,1.
  task automatic drain(input int max_cyc, input int mode);
    logic [3:0] pat;
    int         k;
    logic       r;
    pat = 4'b1001;
    k   = 0;
    while (q_a.size() != 0 && k < max_cyc) begin
      r = (mode == 1) ? pat[k % 4] : 1'b1;
      cyc(8'h00, 1'b0, r);
      k++;
    end
    chk("drain_left", q_a.size(), 0);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_val"}, {31'b0, val_a | val_b}, 32'd0);
    chk({tag, "_oh"}, {16'b0, oh_a, oh_b}, 32'd0);
    chk({tag, "_idx"}, {26'b0, idx_a, idx_b}, 32'd0);
    chk({tag, "_last"}, {30'b0, last_a, last_b}, 32'd0);
    chk({tag, "_zero"}, {30'b0, zero_a, zero_b}, 32'd0);
    chk({tag, "_lr"}, {left_a, right_a, left_b, right_b}, 32'd0);
  endtask

  initial begin
    srst_i     = 1'b1;
    data_i     = 8'h00;
    data_val_i = 1'b0;
    bit_rdy_i  = 1'b0;
    exp_left   = 8'h00;
    exp_right  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    srst_i = 1'b0;
    #1;
    chk_idle_zero("reset");
    chk("reset_rdy", {30'b0, rdy_a, rdy_b}, 32'd3);
    @(negedge clk);

    // Basic word, one beat per cycle, first beat one cycle after accept.
    cyc(8'b1010_0100, 1'b1, 1'b1);
    drain(10, 0);
    cyc(8'h00, 1'b0, 1'b1);

    // All-zero word.
    cyc(8'h00, 1'b1, 1'b1);
    drain(10, 0);

    // All-ones word under backpressure.
    cyc(8'hFF, 1'b1, 1'b1);
    drain(40, 1);

    // Back-to-back: second word taken on the first word's last beat.
    cyc(8'h01, 1'b1, 1'b1);
    cyc(8'h81, 1'b1, 1'b1);
    drain(10, 0);

    // Reset in the middle of a scan.
    cyc(8'hF0, 1'b1, 1'b1);
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b1);
    srst_i = 1'b1;
    #1;
    chk_idle_zero("midrst");
    q_a.delete();
    q_b.delete();
    exp_left  = 8'h00;
    exp_right = 8'h00;
    @(negedge clk);
    srst_i = 1'b0;
    cyc(8'h00, 1'b0, 1'b1);

    // Random words, valid and ready.
    for (int i = 0; i < 60; i++) begin
      cyc(8'($urandom), 1'($urandom), 1'($urandom));
    end
    drain(40, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_priority_encoder_stream
`default_nettype wire
